// File: rtl/mem_bank.sv
// mem_bank: DEPTH x WIDTH storage bank with byte-enabled write port, 1-cycle registered read
// and an internal clear sequencer. Optional macro MEM_BANK_FWD_EN selects write-first forwarding.
module mem_bank #(
    parameter int WIDTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    output logic                 busy,
    input  logic                 wsel,
    input  logic                 wr,
    input  logic [ADDR_W-1:0]    waddr,
    input  logic [WIDTH/8-1:0]   wbe,
    input  logic [WIDTH-1:0]     wdata,
    input  logic                 rsel,
    input  logic [ADDR_W-1:0]    raddr,
    output logic [WIDTH-1:0]     rdata,
    output logic                 rvalid
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam int NBE   = WIDTH / 8;

    typedef enum logic {
        S_CLEAR = 1'b0,
        S_IDLE  = 1'b1
    } state_t;

    state_t              r_state;
    logic [ADDR_W-1:0]   r_cptr;
    logic                r_busy;
    logic [WIDTH-1:0]    r_rdata;
    logic                r_rvalid;
    logic [WIDTH-1:0]    r_mem [DEPTH];

    logic                w_access_ok;
    logic                w_wr_en;
    logic                w_rd_en;
    logic [WIDTH-1:0]    w_merged;
    logic [WIDTH-1:0]    w_rd_word;

    function automatic logic [WIDTH-1:0] byte_merge(
        input logic [WIDTH-1:0] old_word,
        input logic [WIDTH-1:0] new_word,
        input logic [NBE-1:0]   be
    );
        logic [WIDTH-1:0] res;
        res = old_word;
        for (int i = 0; i < NBE; i++) begin
            if (be[i]) begin
                res[8*i +: 8] = new_word[8*i +: 8];
            end else begin
                res[8*i +: 8] = old_word[8*i +: 8];
            end
        end
        return res;
    endfunction

    // clr takes priority over any access presented in the same idle cycle
    assign w_access_ok = (r_state == S_IDLE) & ~clr;
    assign w_wr_en     = w_access_ok & wsel & wr;
    assign w_rd_en     = w_access_ok & rsel;
    assign w_merged    = byte_merge(r_mem[waddr], wdata, wbe);

`ifdef MEM_BANK_FWD_EN
    assign w_rd_word = (w_wr_en && (waddr == raddr)) ? w_merged : r_mem[raddr];
`else
    assign w_rd_word = r_mem[raddr];
`endif

    // Clear sequencer: sweeps every address once after reset or a clr request
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_CLEAR;
            r_cptr  <= '0;
            r_busy  <= 1'b1;
        end else begin
            case (r_state)
                S_CLEAR: begin
                    if (clr) begin
                        r_state <= S_CLEAR;
                        r_cptr  <= '0;
                        r_busy  <= 1'b1;
                    end else if (r_cptr == ADDR_W'(DEPTH - 1)) begin
                        r_state <= S_IDLE;
                        r_cptr  <= '0;
                        r_busy  <= 1'b0;
                    end else begin
                        r_state <= S_CLEAR;
                        r_cptr  <= r_cptr + ADDR_W'(1);
                        r_busy  <= 1'b1;
                    end
                end
                S_IDLE: begin
                    if (clr) begin
                        r_state <= S_CLEAR;
                        r_cptr  <= '0;
                        r_busy  <= 1'b1;
                    end else begin
                        r_state <= S_IDLE;
                        r_cptr  <= '0;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_CLEAR;
                    r_cptr  <= '0;
                    r_busy  <= 1'b1;
                end
            endcase
        end
    end

    // Storage array: no reset, contents are zeroed by the sequencer instead
    always_ff @(posedge clk) begin
        if (r_state == S_CLEAR) begin
            r_mem[r_cptr] <= '0;
        end else if (w_wr_en) begin
            r_mem[waddr] <= w_merged;
        end else begin
            r_mem[waddr] <= r_mem[waddr];
        end
    end

    // Read port: data is forced to zero whenever no read was accepted
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
        end else if (w_rd_en) begin
            r_rvalid <= 1'b1;
            r_rdata  <= w_rd_word;
        end else begin
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
        end
    end

    assign busy   = r_busy;
    assign rdata  = r_rdata;
    assign rvalid = r_rvalid;

endmodule

// File: tb/tb_mem_bank.sv
// Scoreboard bench for mem_bank (WIDTH=16, ADDR_W=4): directed plan items plus random traffic
// checked against an array-based reference model.
module tb_mem_bank;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clr = 1'b0;
    logic        busy;
    logic        wsel = 1'b0;
    logic        wr = 1'b0;
    logic [3:0]  waddr = 4'd0;
    logic [1:0]  wbe = 2'b00;
    logic [15:0] wdata = 16'h0000;
    logic        rsel = 1'b0;
    logic [3:0]  raddr = 4'd0;
    logic [15:0] rdata;
    logic        rvalid;

    mem_bank #(.WIDTH(16), .ADDR_W(4)) dut (
        .clk(clk), .rst(rst), .clr(clr), .busy(busy),
        .wsel(wsel), .wr(wr), .waddr(waddr), .wbe(wbe), .wdata(wdata),
        .rsel(rsel), .raddr(raddr), .rdata(rdata), .rvalid(rvalid)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        logic [15:0] data;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] model_mem [16];
    int          busy_win = 0;
    int          cyc = 0;
    int          n_checks = 0;
    int          n_pass = 0;
    logic        last_busy;

    // cycle counter used to time-stamp expected read results
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
    endtask

    function automatic logic [15:0] merge(input logic [15:0] old_w, input logic [15:0] new_w,
                                          input logic [1:0] be);
        logic [15:0] r;
        r = old_w;
        for (int b = 0; b < 2; b++)
            if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
        return r;
    endfunction

    task automatic model_clear();
        for (int a = 0; a < 16; a++) model_mem[a] = 16'h0000;
    endtask

    // one cycle of stimulus applied just after the rising edge, plus its model update
    task automatic apply(input logic c, input logic ws, input logic w, input logic [3:0] wa,
                         input logic [1:0] be, input logic [15:0] wd,
                         input logic rs, input logic [3:0] ra);
        exp_t e;
        logic [15:0] nw;
        @(posedge clk);
        #1;
        last_busy = busy;
        check("busy", {31'd0, busy}, {31'd0, busy_win > 0});
        clr = c; wsel = ws; wr = w; waddr = wa; wbe = be; wdata = wd; rsel = rs; raddr = ra;
        if (busy_win > 0) begin
            busy_win--;
            if (c) begin
                busy_win = 16;
                model_clear();
            end
        end else if (c) begin
            busy_win = 16;
            model_clear();
        end else begin
            nw = merge(model_mem[wa], wd, be);
            if (rs) begin
                e.due = cyc + 1;
                e.data = model_mem[ra];
`ifdef MEM_BANK_FWD_EN
                if (ws && w && wa == ra) e.data = nw;
`endif
                sb.push_back(e);
            end
            if (ws && w) model_mem[wa] = nw;
        end
    endtask

    task automatic idle();
        apply(1'b0, 1'b0, 1'b0, 4'd0, 2'b00, 16'h0000, 1'b0, 4'd0);
    endtask

    task automatic wr_op(input logic [3:0] a, input logic [1:0] be, input logic [15:0] d);
        apply(1'b0, 1'b1, 1'b1, a, be, d, 1'b0, 4'd0);
    endtask

    task automatic rd_op(input logic [3:0] a);
        apply(1'b0, 1'b0, 1'b0, 4'd0, 2'b00, 16'h0000, 1'b1, a);
    endtask

    task automatic release_rst(output int cnt);
        @(posedge clk);
        #1;
        cnt = busy ? 1 : 0;
        rst = 1'b0;
        clr = 1'b0; wsel = 1'b0; wr = 1'b0; rsel = 1'b0;
        busy_win = 15;
        model_clear();
        sb.delete();
        for (int k = 0; k < 19; k++) begin
            idle();
            if (last_busy) cnt++;
        end
    endtask

    // monitor: compares each read result against the scoreboard head when it falls due
    always @(negedge clk) begin
        if (!rst) begin
            if (sb.size() > 0 && sb[0].due == cyc) begin
                check("rdata_valid", {15'd0, rvalid, rdata}, {15'd0, 1'b1, sb[0].data});
                void'(sb.pop_front());
            end else begin
                check("idle_out", {15'd0, rvalid, rdata}, 32'd0);
            end
        end
    end

    initial begin
        int cnt;
        logic [3:0] a;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", {31'd0, busy}, 32'd1);
        check("rst_out", {15'd0, rvalid, rdata}, 32'd0);

        release_rst(cnt);
        check("busy_len", cnt, 32'd16);
        for (int k = 0; k < 16; k++) rd_op(4'(k));

        wr_op(4'd3, 2'b11, 16'hABCD);
        wr_op(4'd3, 2'b01, 16'h12FF);
        rd_op(4'd3);
        wr_op(4'd0, 2'b11, 16'h1111);
        wr_op(4'd1, 2'b11, 16'h2222);
        rd_op(4'd0);
        rd_op(4'd1);
        idle();
        wr_op(4'd4, 2'b00, 16'hFFFF);
        rd_op(4'd4);

        wr_op(4'd5, 2'b11, 16'h00AA);
        apply(1'b0, 1'b1, 1'b1, 4'd5, 2'b11, 16'h5555, 1'b1, 4'd5);
        rd_op(4'd5);
        apply(1'b0, 1'b1, 1'b1, 4'd6, 2'b11, 16'h7777, 1'b1, 4'd5);

        wr_op(4'd7, 2'b11, 16'hBEEF);
        apply(1'b1, 1'b1, 1'b1, 4'd8, 2'b11, 16'h1234, 1'b1, 4'd7);
        rd_op(4'd7);
        for (int k = 0; k < 16; k++) idle();
        rd_op(4'd7);
        rd_op(4'd8);

        for (int k = 0; k < 400; k++) begin
            a = 4'($urandom_range(0, 15));
            apply(($urandom_range(0, 59) == 0), 1'($urandom), 1'($urandom), a,
                  2'($urandom), 16'($urandom), 1'($urandom),
                  ($urandom_range(0, 1) == 0) ? a : 4'($urandom_range(0, 15)));
        end
        for (int k = 0; k < 18; k++) idle();

        wr_op(4'd9, 2'b11, 16'hC0DE);
        rd_op(4'd9);
        @(posedge clk);
        #1;
        rsel = 1'b1;
        raddr = 4'd9;
        #6;
        rst = 1'b1;
        #1;
        check("async_rst_out", {15'd0, rvalid, rdata}, 32'd0);
        check("async_rst_busy", {31'd0, busy}, 32'd1);
        rsel = 1'b0;
        repeat (2) @(posedge clk);
        release_rst(cnt);
        check("busy_len2", cnt, 32'd16);
        rd_op(4'd9);
        idle();
        idle();
        check("sb_empty", sb.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_bank.md
Name: mem_bank

Overview:
- Parametrised successor to the team's single 16-bit select/write register.
- DEPTH-word × WIDTH-bit storage bank with a separate write port and read port, and per-byte write enables.
- Registered read returns data after a fixed 1 cycle, with a valid flag.
- Contents are cleared by an internal sequencer after reset or on request, so the array itself needs no reset.
- Used as a small local scratch/config memory beside the datapath, on the single system clock.

Parameters:
- WIDTH, 16, data word width in bits; must be a multiple of 8.
- ADDR_W, 4, address width; DEPTH = 2**ADDR_W words.
- NBE (derived localparam), WIDTH/8, number of byte enables.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- clr  input  1  synchronous request to re-clear the whole bank.
- busy  output  1  high while the clear sequencer runs; all accesses are ignored while high.
- wsel  input  1  write port select.
- wr  input  1  write strobe; a write occurs when wsel & wr & !busy.
- waddr  input  ADDR_W  write address.
- wbe  input  NBE  byte enables; bit i gates wdata[8i+7:8i].
- wdata  input  WIDTH  write data.
- rsel  input  1  read request; accepted when rsel & !busy.
- raddr  input  ADDR_W  read address.
- rdata  output  WIDTH  read data; zero whenever rvalid = 0.
- rvalid  output  1  rdata holds the result of the read accepted on the previous cycle.

Behaviour:
- Reset (rst = 1, asynchronous):
  - busy = 1, rvalid = 0, rdata = 0.
  - Sequencer enters CLEAR with clear pointer cptr = 0.
  - Array contents are not reset directly.
- States:
  - CLEAR: each cycle writes 0 to mem[cptr], then cptr++. In the cycle cptr = DEPTH-1 the state moves to IDLE and busy falls on the next edge.
  - busy therefore stays high for exactly DEPTH cycles after rst deasserts.
  - IDLE: busy = 0; normal access.
  - clr = 1 in IDLE → CLEAR with cptr = 0; busy = 1 from the next edge.
  - clr = 1 in CLEAR → cptr restarts at 0.
- Write (IDLE, wsel & wr):
  - For each i with wbe[i] = 1, mem[waddr] byte i ← wdata byte i.
  - Bytes with wbe[i] = 0 keep their value.
  - wbe = 0 is a legal no-op.
- Read (IDLE, rsel):
  - Next edge: rvalid ← 1, rdata ← mem[raddr]. Latency is 1 cycle.
  - A new read can be accepted every cycle.
- No read accepted: next edge rvalid ← 0, rdata ← 0. Outputs are never left holding stale data.
- Accesses while busy = 1 are dropped: no write, rvalid = 0.
- clr and an access in the same IDLE cycle: the access is dropped and clr wins.
- Simultaneous read and write at different addresses: both complete; rdata returns the stored old value of raddr.
- Simultaneous read and write at the same address: see Optional Feature.
- Reset mid-operation:
  - Pending rvalid is cancelled immediately (asynchronous).
  - A write on the same edge as rst assertion is not guaranteed.
  - The sequencer restarts the clear from address 0.
- Address width: the address is exactly ADDR_W bits, so no out-of-range access exists.

Optional Feature:
- Macro: MEM_BANK_FWD_EN.
- Defined: a same-cycle read and write to the same address return the merged value, i.e. new bytes where wbe = 1 and old bytes elsewhere (write-first forwarding).
- Not defined: the read returns the pre-write value (read-first); the write still lands.
- Applies only in IDLE; busy-state behaviour is unchanged.

Test Plan (WIDTH=16, ADDR_W=4):
- Reset/clear: pulse rst, release → busy high for exactly 16 cycles, then 0; reading all 16 addresses returns 0x0000 with rvalid = 1 one cycle after each request.
- Byte-enable write: write 0xABCD with wbe = 2'b11 to addr 3, then 0x12FF with wbe = 2'b01 to addr 3; read addr 3 → rdata = 0xABFF one cycle later.
- Back-to-back reads: write 0x1111 to addr 0 and 0x2222 to addr 1; assert rsel for 2 consecutive cycles at addr 0 then 1 → rdata 0x1111 then 0x2222 on consecutive cycles; rvalid = 0 and rdata = 0 on the following cycle.
- Same-address collision: addr 5 holds 0x00AA; write 0x5555 (wbe = 2'b11) and read addr 5 in the same cycle → rdata = 0x5555 with MEM_BANK_FWD_EN defined, 0x00AA without; a later read returns 0x5555 in both builds.
- Mid-run clr: addr 7 = 0xBEEF; pulse clr together with a write of 0x1234 to addr 8 → write dropped, busy high for 16 cycles; afterwards addr 7 and addr 8 both read 0x0000.
- Async reset during read: assert rsel, then raise rst mid-cycle before the edge → rvalid = 0 and rdata = 0 immediately; busy = 1.
